sprite_overlay: RTL and testbench
=================================

SPRITE_OVERLAY -- requirements
Module: sprite_overlay

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- SPR_W, 24, sprite width in texels.
- SPR_H, 32, sprite height in texels.
- SCALE_LOG2, 0, integer magnification: each texel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels.
- PAL_BITS, 1, palette index width.
- TRANSPARENT_IDX, 0, palette index that shows the background.
- BLINK_FRAMES, 30, frames per blink half-period.
- ADDR_W, $clog2(SPR_W*SPR_H), ROM address width.

REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- vga_clk, in, 1, pixel clock; all logic uses the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- DrawX, in, 10, current pixel column.
- DrawY, in, 10, current pixel row.
- blank, in, 1, 1 = active video.
- enable, in, 1, 1 = sprite drawn; 0 = background passthrough.
- pos_x, in, 10, requested sprite left edge.
- pos_y, in, 10, requested sprite top edge.
- pos_valid, in, 1, 1-cycle strobe that captures pos_x/pos_y.
- bg_red, bg_green, bg_blue, in, 4 each, background pixel.
- rom_addr, out, ADDR_W, registered sprite ROM address.
- rom_q, in, PAL_BITS, ROM data; synchronous read, valid 1 cycle after rom_addr.
- pal_idx, out, PAL_BITS, index to the external combinational palette (equals rom_q).
- pal_red, pal_green, pal_blue, in, 4 each, palette colour for pal_idx.
- red, green, blue, out, 4 each, registered output pixel.

Function
REQ-003 Pipeline: inputs sampled at edge k SHALL produce red/green/blue at edge k+3. Stage 1 registers rom_addr, hit, blank, enable and bg. Stage 2 waits for ROM data and delays the sideband. Stage 3 registers the output.
REQ-004 Position SHALL be double-buffered:
- pos_valid loads the pending registers (pend_x, pend_y).
- At frame start (DrawX==0 && DrawY==0 sampled), pend_x/pend_y are copied to the active registers (act_x, act_y).
- If pos_valid coincides with frame start, the new pos_x/pos_y go directly to both pending and active registers.
REQ-005 Hit rule: hit SHALL be asserted iff act_x <= DrawX < act_x + (SPR_W<<SCALE_LOG2) and act_y <= DrawY < act_y + (SPR_H<<SCALE_LOG2).
- The comparison is computed 11+SCALE_LOG2 bits wide, so a sprite near 1023 clips and never wraps to column/row 0.
REQ-006 Address: on hit, rom_addr SHALL equal ((DrawX-act_x)>>SCALE_LOG2) + ((DrawY-act_y)>>SCALE_LOG2)*SPR_W; on non-hit, rom_addr SHALL be 0.
REQ-007 Output select at stage 3, first matching rule wins:
- blank==0 -> 0.
- enable==0, or hit==0, or visible==0 -> bg.
- rom_q==TRANSPARENT_IDX -> bg.
- otherwise -> pal_red/pal_green/pal_blue.
REQ-008 Sideband values (blank, enable, hit, bg) SHALL be delayed exactly in step with the ROM data, with no skew between them.
REQ-009 enable SHALL take effect per pixel with the same 3-cycle latency as the pixel data.

Reset
REQ-010 While reset_n==0 the following SHALL hold:
- red, green, blue = 0; rom_addr = 0.
- All pipeline registers = 0.
- act_x, act_y, pend_x, pend_y = 0.
- Blink counter = 0; visible = 1.
REQ-011 Reset asserted mid-frame SHALL clear the pipeline immediately. The first valid pixel SHALL appear 3 edges after release.

Configuration
REQ-012 Macro SPRITE_OVERLAY_BLINK_EN SHALL control blinking.
- Defined: a frame counter increments at each frame start. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles visible.
- Undefined: no counter is synthesised and visible is constant 1.

Verification
REQ-013 The bench SHALL cover these directed scenarios:
- Defaults, act=(100,50), DrawX=100, DrawY=50, rom_q=1, pal=F/0/0 -> rom_addr=0; red=F green=0 blue=0 at edge k+3.
- DrawX=123, DrawY=81, act=(100,50) -> rom_addr=23+31*24=767; DrawX=124 -> hit=0, output = bg.
- SCALE_LOG2=1, act=(0,0), DrawX=5, DrawY=3 -> rom_addr=2+1*24=26.
- pos_valid with (200,200) mid-frame -> sprite stays at the old position until the next (0,0) pixel, then moves; pos_valid at (0,0) -> moves that same frame.
- rom_q=TRANSPARENT_IDX -> bg passes through; blank=0 -> output 0 regardless; act_x=1020 -> no hit at DrawX 0-3.
- With SPRITE_OVERLAY_BLINK_EN and BLINK_FRAMES=2 -> visible toggles every 2 frames starting from 1; reset mid-blink -> visible=1, counter=0.

Source files
------------

// File: rtl/sprite_overlay.sv
// sprite_overlay: overlays a palettized ROM sprite onto a background video stream.
//
// Ports
//   vga_clk, reset_n            pixel clock (rising edge), async active-low reset
//   DrawX, DrawY, blank         current raster position, 1 = active video
//   enable                      1 = sprite drawn, 0 = background passthrough
//   pos_x, pos_y, pos_valid     requested sprite top-left, 1-cycle capture strobe
//   bg_red/green/blue           background pixel
//   rom_addr / rom_q            registered ROM address / synchronous ROM data
//   pal_idx, pal_red/green/blue palette index out, combinational palette colour in
//   red, green, blue            registered output pixel, 3 edges after the inputs
//
// Configuration
//   SPRITE_OVERLAY_BLINK_EN     when defined, the sprite blinks with a half-period of
//                               BLINK_FRAMES frames; otherwise it is always visible.
module sprite_overlay #(
    parameter int SPR_W           = 24,
    parameter int SPR_H           = 32,
    parameter int SCALE_LOG2      = 0,
    parameter int PAL_BITS        = 1,
    parameter int TRANSPARENT_IDX = 0,
    parameter int BLINK_FRAMES    = 30,
    parameter int ADDR_W          = $clog2(SPR_W*SPR_H)
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic                enable,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                pos_valid,
    input  logic [3:0]          bg_red,
    input  logic [3:0]          bg_green,
    input  logic [3:0]          bg_blue,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PAL_BITS-1:0] rom_q,
    output logic [PAL_BITS-1:0] pal_idx,
    input  logic [3:0]          pal_red,
    input  logic [3:0]          pal_green,
    input  logic [3:0]          pal_blue,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue
);

    // Extents are compared one bit wider than the raster so a sprite placed
    // near column/row 1023 clips instead of wrapping back to 0.
    localparam int HW = 11 + SCALE_LOG2;
    localparam logic [HW-1:0] EXT_W = HW'(SPR_W << SCALE_LOG2);
    localparam logic [HW-1:0] EXT_H = HW'(SPR_H << SCALE_LOG2);

    typedef struct packed {
        logic        blank;
        logic        enable;
        logic        hit;
        logic        vis;
        logic [11:0] bg;
    } side_t;

    logic              frame_start;
    logic [9:0]        pend_x, pend_y, act_x, act_y;
    logic [9:0]        eff_x, eff_y;
    logic [9:0]        off_x, off_y;
    logic              hit;
    logic [ADDR_W-1:0] addr_calc;
    logic              vis;
    side_t             s1, s2;
    logic [11:0]       pix_q;

    // The frame-start pixel already uses the position being committed that
    // cycle, so a move takes effect for the entire new frame.
    always_comb begin
        frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
        eff_x = act_x;
        eff_y = act_y;
        if (frame_start) begin
            eff_x = pos_valid ? pos_x : pend_x;
            eff_y = pos_valid ? pos_y : pend_y;
        end
        hit = (HW'(DrawX) >= HW'(eff_x)) && (HW'(DrawX) < HW'(eff_x) + EXT_W) &&
              (HW'(DrawY) >= HW'(eff_y)) && (HW'(DrawY) < HW'(eff_y) + EXT_H);
        off_x = DrawX - eff_x;
        off_y = DrawY - eff_y;
        addr_calc = ADDR_W'(off_x >> SCALE_LOG2) +
                    ADDR_W'(off_y >> SCALE_LOG2) * ADDR_W'(SPR_W);
    end

    // Double-buffered position: pending follows pos_valid, active follows frame start.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
        end else begin
            if (pos_valid) begin
                pend_x <= pos_x;
                pend_y <= pos_y;
            end
            if (frame_start) begin
                act_x <= eff_x;
                act_y <= eff_y;
            end
        end
    end

`ifdef SPRITE_OVERLAY_BLINK_EN
    localparam int CW = $clog2(BLINK_FRAMES + 1);
    logic [CW-1:0] blink_cnt;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            vis       <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                vis       <= ~vis;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_FRAMES;
    assign vis = 1'b1;
`endif

    // Stage 1: address and sideband capture. Stage 2: sideband waits out the
    // ROM read so it lines up with rom_q. Stage 3: output select.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            s1       <= '0;
            s2       <= '0;
            pix_q    <= '0;
        end else begin
            rom_addr <= hit ? addr_calc : '0;
            s1       <= '{blank, enable, hit, vis, {bg_red, bg_green, bg_blue}};
            s2       <= s1;
            if (!s2.blank)
                pix_q <= '0;
            else if (!s2.enable || !s2.hit || !s2.vis ||
                     rom_q == PAL_BITS'(TRANSPARENT_IDX))
                pix_q <= s2.bg;
            else
                pix_q <= {pal_red, pal_green, pal_blue};
        end
    end

    assign pal_idx = rom_q;
    assign {red, green, blue} = pix_q;

endmodule

// File: tb/tb_sprite_overlay.sv
module tb_sprite_overlay;

    localparam logic [11:0] RED  = 12'hF00;
    localparam logic [11:0] BG   = 12'hABC;
    localparam logic [11:0] ZERO = 12'h000;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;
    logic       blank, enable, pos_valid;
    logic       pos_valid2 = 1'b0;
    logic [3:0] bg_red = 4'hA, bg_green = 4'hB, bg_blue = 4'hC;

    logic [9:0] rom_addr, rom_addr2;
    logic       rom_q = 1'b0, rom_q2 = 1'b0;
    logic       pal_idx, pal_idx2;
    logic [3:0] red, green, blue, red2, green2, blue2;
    logic [3:0] pal_red, pal_green, pal_blue, pal_red2, pal_green2, pal_blue2;
    logic       mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM model shared by both instances; external palette:
    // index 1 -> F/0/0, index 0 -> 5/6/7.
    always @(posedge vga_clk) begin
        rom_q  <= mem[rom_addr];
        rom_q2 <= mem[rom_addr2];
    end
    assign {pal_red,  pal_green,  pal_blue}  = pal_idx  ? 12'hF00 : 12'h567;
    assign {pal_red2, pal_green2, pal_blue2} = pal_idx2 ? 12'hF00 : 12'h567;

    sprite_overlay dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .enable(enable), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue)
    );

    // Magnified, fast-blinking instance; its position stays at (0,0).
    sprite_overlay #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .enable(enable), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid2), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr2), .rom_q(rom_q2), .pal_idx(pal_idx2),
        .pal_red(pal_red2), .pal_green(pal_green2), .pal_blue(pal_blue2),
        .red(red2), .green(green2), .blue(blue2)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
    endtask

    // One frame-start pixel, optionally carrying a position strobe.
    task automatic frame(input logic load, input logic [9:0] x, input logic [9:0] y);
        pix(10'd0, 10'd0);
        pos_x = x; pos_y = y; pos_valid = load;
        tick();
        pos_valid = 1'b0;
        pix(10'd500, 10'd500);
    endtask

    task automatic pulse_reset();
        pix(10'd500, 10'd500);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; blank = 1'b1; enable = 1'b1; pos_valid = 1'b0;
        pos_x = '0; pos_y = '0;
        pix(10'd500, 10'd500);
        tick(); tick();
        n_cmp++;
        if ({red, green, blue} !== ZERO) begin
            n_bad++; $display("FAIL reset_rgb: got %h want %h", {red, green, blue}, ZERO);
        end
        n_cmp++;
        if (rom_addr !== 10'd0 || rom_addr2 !== 10'd0) begin
            n_bad++; $display("FAIL reset_rom_addr: got %0d/%0d want 0", rom_addr, rom_addr2);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_scale_blink();
        logic [11:0] exp_pix [7];
`ifdef SPRITE_OVERLAY_BLINK_EN
        exp_pix = '{RED, BG, BG, RED, RED, BG, BG};
`else
        exp_pix = '{RED, RED, RED, RED, RED, RED, RED};
`endif
        pix(10'd5, 10'd3);
        tick();
        n_cmp++;
        if (rom_addr2 !== 10'd26) begin
            n_bad++; $display("FAIL scale_addr: got %0d want 26", rom_addr2);
        end
        tick(); tick();
        n_cmp++;
        if ({red2, green2, blue2} !== RED) begin
            n_bad++; $display("FAIL scale_pixel: got %h want %h", {red2, green2, blue2}, RED);
        end
        for (int i = 0; i < 7; i++) begin
            frame(1'b0, 10'd0, 10'd0);
            pix(10'd5, 10'd3);
            tick(); tick(); tick();
            n_cmp++;
            if ({red2, green2, blue2} !== exp_pix[i]) begin
                n_bad++;
                $display("FAIL blink_frame%0d: got %h want %h", i + 1, {red2, green2, blue2}, exp_pix[i]);
            end
        end
        // Reset with the counter mid-period must restart from visible, count 0.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) frame(1'b0, 10'd0, 10'd0);
            pix(10'd5, 10'd3);
            tick(); tick(); tick();
            n_cmp++;
`ifdef SPRITE_OVERLAY_BLINK_EN
            if ({red2, green2, blue2} !== ((i == 2) ? BG : RED)) begin
`else
            if ({red2, green2, blue2} !== RED) begin
`endif
                n_bad++; $display("FAIL blink_after_reset%0d: got %h", i, {red2, green2, blue2});
            end
        end
    endtask

    task automatic test_basic();
        frame(1'b1, 10'd100, 10'd50);
        pix(10'd100, 10'd50);
        tick();
        n_cmp++;
        if (rom_addr !== 10'd0) begin
            n_bad++; $display("FAIL basic_addr: got %0d want 0", rom_addr);
        end
        tick();
        // Still showing the preceding (0,0) pixel, which misses the sprite.
        n_cmp++;
        if ({red, green, blue} !== BG) begin
            n_bad++; $display("FAIL basic_latency: got %h want %h", {red, green, blue}, BG);
        end
        tick();
        n_cmp++;
        if ({red, green, blue} !== RED) begin
            n_bad++; $display("FAIL basic_pixel: got %h want %h", {red, green, blue}, RED);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  xs   [3] = '{10'd122, 10'd123, 10'd124};
        logic [9:0]  addrs[3] = '{10'd766, 10'd767, 10'd0};
        logic [11:0] outs [3] = '{RED, BG, BG};
        DrawY = 10'd81;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) DrawX = xs[i];
            tick();
            if (i < 3) begin
                n_cmp++;
                if (rom_addr !== addrs[i]) begin
                    n_bad++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, rom_addr, addrs[i]);
                end
            end
            if (i >= 2) begin
                n_cmp++;
                if ({red, green, blue} !== outs[i-2]) begin
                    n_bad++;
                    $display("FAIL b2b_pixel%0d: got %h want %h", i - 2, {red, green, blue}, outs[i-2]);
                end
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [9:0]  px [5] = '{10'd100, 10'd200, 10'd200, 10'd100, 10'd100};
        logic [11:0] ex [5] = '{RED, BG, RED, BG, RED};
        pix(10'd10, 10'd10);
        pos_x = 10'd200; pos_y = 10'd200; pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) frame(1'b0, 10'd0, 10'd0);
            if (i == 4) frame(1'b1, 10'd100, 10'd50);
            pix(px[i], (px[i] == 10'd100) ? 10'd50 : 10'd200);
            tick(); tick(); tick();
            n_cmp++;
            if ({red, green, blue} !== ex[i]) begin
                n_bad++; $display("FAIL dbuf_step%0d: got %h want %h", i, {red, green, blue}, ex[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic        ens [3] = '{1'b1, 1'b0, 1'b1};
        logic [11:0] outs[3] = '{RED, BG, RED};
        pix(10'd100, 10'd50);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) enable = ens[i];
            tick();
            if (i >= 2) begin
                n_cmp++;
                if ({red, green, blue} !== outs[i-2]) begin
                    n_bad++;
                    $display("FAIL enable_pixel%0d: got %h want %h", i - 2, {red, green, blue}, outs[i-2]);
                end
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_blank();
        pix(10'd100, 10'd50);
        blank = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({red, green, blue} !== ZERO) begin
            n_bad++; $display("FAIL blank_pixel: got %h want %h", {red, green, blue}, ZERO);
        end
        blank = 1'b1;
    endtask

    task automatic test_clip();
        frame(1'b1, 10'd1020, 10'd50);
        for (int x = 0; x < 4; x++) begin
            pix(10'(x), 10'd50);
            tick();
            n_cmp++;
            if (rom_addr !== 10'd0) begin
                n_bad++; $display("FAIL clip_addr_x%0d: got %0d want 0", x, rom_addr);
            end
            tick(); tick();
            n_cmp++;
            if ({red, green, blue} !== BG) begin
                n_bad++; $display("FAIL clip_pixel_x%0d: got %h want %h", x, {red, green, blue}, BG);
            end
        end
        pix(10'd1021, 10'd50);
        tick();
        n_cmp++;
        if (rom_addr !== 10'd1) begin
            n_bad++; $display("FAIL clip_edge_addr: got %0d want 1", rom_addr);
        end
        tick(); tick();
        n_cmp++;
        if ({red, green, blue} !== RED) begin
            n_bad++; $display("FAIL clip_edge_pixel: got %h want %h", {red, green, blue}, RED);
        end
    endtask

    task automatic test_mid_reset();
        frame(1'b1, 10'd100, 10'd50);
        pix(10'd100, 10'd50);
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({red, green, blue} !== ZERO || rom_addr !== 10'd0) begin
            n_bad++; $display("FAIL midreset_clear: got %h/%0d want 000/0", {red, green, blue}, rom_addr);
        end
        tick();
        reset_n = 1'b1;
        // Position was cleared to (0,0); pixel (0,0) hits texel 0.
        pix(10'd0, 10'd0);
        tick(); tick();
        n_cmp++;
        if ({red, green, blue} !== ZERO) begin
            n_bad++; $display("FAIL midreset_early: got %h want %h", {red, green, blue}, ZERO);
        end
        tick();
        n_cmp++;
        if ({red, green, blue} !== RED) begin
            n_bad++; $display("FAIL midreset_first: got %h want %h", {red, green, blue}, RED);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 1'b1;
        mem[767] = 1'b0;
        test_reset();
        test_scale_blink();
        test_basic();
        test_back_to_back();
        test_double_buffer();
        test_enable();
        test_blank();
        test_clip();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
